decode_stage: RTL and testbench

- Fetch-to-execute pipeline register for the RISC-V core.
- Latches the fetched instruction and PC, and decodes the opcode into the 3-bit immediate select consumed by the immediate generator.
- Also extracts rd/rs1/rs2 and flags illegal opcodes.
- Valid/ready handshake on both sides; synchronous flush for branch/jump redirects.

---
 rtl/decode_stage.sv | 142 ++++++++++++++
 tb/tb_decode_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Fetch-to-execute pipeline register with opcode decode (immediate select, register fields, illegal flag).
// Optional macro DECODE_SKID_EN adds a 1-entry skid buffer so in_ready is a pure register output.
module decode_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [2:0]  out_imm_sel,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic        out_illegal
);

  // Handshake: a transfer happens on a side only in a cycle where valid and ready are both high
  // at the rising edge; a held output never changes until it is consumed or flushed.

  typedef struct packed {
    logic [2:0] imm_sel;
    logic       illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t d;
    d.imm_sel = 3'd0;
    d.illegal = 1'b0;
    case (inst[6:0])
      7'b0110111, 7'b0010111: d.imm_sel = 3'd3;
      7'b1101111:             d.imm_sel = 3'd4;
      7'b1100111, 7'b0000011,
      7'b0010011:             d.imm_sel = 3'd0;
      7'b1100011:             d.imm_sel = 3'd2;
      7'b0100011:             d.imm_sel = 3'd1;
      7'b0110011:             d.imm_sel = 3'd0;
      // CSR forms with funct3[2] set carry a 5-bit zero-extended immediate in rs1
      7'b1110011:             d.imm_sel = inst[14] ? 3'd5 : 3'd0;
      default:                d.illegal = 1'b1;
    endcase
    if (inst[1:0] != 2'b11) d.illegal = 1'b1;
    return d;
  endfunction

  dec_t in_dec;
  logic in_fire;
  logic out_fire;

  assign in_dec   = decode(in_inst);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  assign out_rd  = out_inst[11:7];
  assign out_rs1 = out_inst[19:15];
  assign out_rs2 = out_inst[24:20];

`ifdef DECODE_SKID_EN
  logic        skid_valid;
  logic [31:0] skid_inst;
  logic [31:0] skid_pc;
  dec_t        skid_dec;

  assign in_ready = ~skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_inst    <= NOP_INST;
      out_pc      <= PC_RESET;
      out_imm_sel <= 3'd0;
      out_illegal <= 1'b0;
      skid_valid  <= 1'b0;
      skid_inst   <= NOP_INST;
      skid_pc     <= PC_RESET;
      skid_dec    <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_inst    <= NOP_INST;
      out_imm_sel <= 3'd0;
      out_illegal <= 1'b0;
      skid_valid  <= 1'b0;
    end else if (out_valid && !out_ready) begin
      // Output stalled: park the arriving instruction in the skid slot
      if (in_fire) begin
        skid_valid <= 1'b1;
        skid_inst  <= in_inst;
        skid_pc    <= in_pc;
        skid_dec   <= in_dec;
      end
    end else if (skid_valid) begin
      out_valid   <= 1'b1;
      out_inst    <= skid_inst;
      out_pc      <= skid_pc;
      out_imm_sel <= skid_dec.imm_sel;
      out_illegal <= skid_dec.illegal;
      skid_valid  <= 1'b0;
    end else if (in_fire) begin
      out_valid   <= 1'b1;
      out_inst    <= in_inst;
      out_pc      <= in_pc;
      out_imm_sel <= in_dec.imm_sel;
      out_illegal <= in_dec.illegal;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end
`else
  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_inst    <= NOP_INST;
      out_pc      <= PC_RESET;
      out_imm_sel <= 3'd0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_inst    <= NOP_INST;
      out_imm_sel <= 3'd0;
      out_illegal <= 1'b0;
    end else if (in_fire) begin
      out_valid   <= 1'b1;
      out_inst    <= in_inst;
      out_pc      <= in_pc;
      out_imm_sel <= in_dec.imm_sel;
      out_illegal <= in_dec.illegal;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: driver feeds a stimulus queue, monitor pops expected results on out_fire.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  out_imm_sel;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic        out_illegal;

  decode_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inst    (in_inst),
    .in_pc      (in_pc),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_pc     (out_pc),
    .out_imm_sel(out_imm_sel),
    .out_rd     (out_rd),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_illegal(out_illegal)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  sel;
    logic        ill;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } item_t;

  localparam int W = $bits(item_t);
  logic [W-1:0] stim_q[$];
  logic [W-1:0] exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int fire_cnt = 0;
  int last_fire_cyc = 0;

  function automatic logic [W-1:0] mk(input logic [31:0] inst, input logic [31:0] pc,
                                      input logic [2:0] sel, input logic ill,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    item_t it;
    it.inst = inst; it.pc = pc; it.sel = sel; it.ill = ill;
    it.rd = rd; it.rs1 = rs1; it.rs2 = rs2;
    return it;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  initial begin
    logic [W-1:0] it;
    in_valid = 1'b0;
    in_inst  = 32'h0;
    in_pc    = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (stim_q.size() > 0) begin
        it = stim_q[0];
        in_valid = 1'b1;
        in_inst  = it[W-1 -: 32];
        in_pc    = it[W-33 -: 32];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (rst_n && in_valid && in_ready && stim_q.size() > 0) begin
        it = stim_q.pop_front();
        if (!flush) exp_q.push_back(it);
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    item_t e;
    logic        prev_stall;
    logic [31:0] prev_inst;
    prev_stall = 1'b0;
    prev_inst  = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && prev_stall && out_valid) check("stall_hold_inst", out_inst, prev_inst);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got inst %h with empty expected queue", out_inst);
        end else begin
          e = exp_q.pop_front();
          check("out_inst", out_inst, e.inst);
          check("out_pc", out_pc, e.pc);
          check("out_imm_sel", {29'd0, out_imm_sel}, {29'd0, e.sel});
          check("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
          check("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
          check("out_rs1", {27'd0, out_rs1}, {27'd0, e.rs1});
          check("out_rs2", {27'd0, out_rs2}, {27'd0, e.rs2});
          fire_cnt++;
          last_fire_cyc = cyc;
        end
      end
      prev_stall = rst_n && out_valid && !out_ready;
      prev_inst  = out_inst;
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0) && k < 60) begin
      step(1);
      k++;
    end
    n_cmp++;
    if (stim_q.size() != 0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d stim and %0d expected left, required 0/0", name,
               stim_q.size(), exp_q.size());
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k0;
    int f0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #23;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'h0000_0013);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_imm_sel", {29'd0, out_imm_sel}, 32'd0);
    check("rst_illegal", {31'd0, out_illegal}, 32'd0);
    check("rst_rd", {27'd0, out_rd}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // single addi x1,x0,5: out one cycle after acceptance
    step(1);
    k0 = cyc;
    stim_q.push_back(mk(32'h00500093, 32'h100, 3'd0, 1'b0, 5'd1, 5'd0, 5'd5));
    wait_drain("addi");
    check("addi_latency", last_fire_cyc - k0, 32'd2);

    // back-to-back stream, imm_sel 1..5, no bubbles
    k0 = cyc;
    f0 = fire_cnt;
    stim_q.push_back(mk(32'h00112223, 32'h104, 3'd1, 1'b0, 5'd4,  5'd2, 5'd1));
    stim_q.push_back(mk(32'hFE0008E3, 32'h108, 3'd2, 1'b0, 5'd17, 5'd0, 5'd0));
    stim_q.push_back(mk(32'h123450B7, 32'h10C, 3'd3, 1'b0, 5'd1,  5'd8, 5'd3));
    stim_q.push_back(mk(32'h008000EF, 32'h110, 3'd4, 1'b0, 5'd1,  5'd0, 5'd8));
    stim_q.push_back(mk(32'h0052D073, 32'h114, 3'd5, 1'b0, 5'd0,  5'd5, 5'd5));
    wait_drain("stream");
    check("stream_count", fire_cnt - f0, 32'd5);
    check("stream_no_bubble", last_fire_cyc - k0, 32'd6);

    // stall with in_valid held high
    out_ready = 1'b0;
    stim_q.push_back(mk(32'h00500093, 32'h200, 3'd0, 1'b0, 5'd1, 5'd0, 5'd5));
    stim_q.push_back(mk(32'h00112223, 32'h204, 3'd1, 1'b0, 5'd4, 5'd2, 5'd1));
    stim_q.push_back(mk(32'h002081B3, 32'h208, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2));
    step(5);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    check("stall_out_valid", {31'd0, out_valid}, 32'd1);
    check("stall_out_inst", out_inst, 32'h00500093);
    out_ready = 1'b1;
    wait_drain("stall");

    // flush with a held instruction and another one arriving
    out_ready = 1'b0;
    stim_q.push_back(mk(32'h00500093, 32'h300, 3'd0, 1'b0, 5'd1, 5'd0, 5'd5));
    stim_q.push_back(mk(32'h00112223, 32'h304, 3'd1, 1'b0, 5'd4, 5'd2, 5'd1));
    step(2);
    check("preflush_out_valid", {31'd0, out_valid}, 32'd1);
    check("preflush_in_valid", {31'd0, in_valid}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    stim_q.delete();
    exp_q.delete();
    #1;
    flush = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_out_inst", out_inst, 32'h0000_0013);
    check("flush_out_pc", out_pc, 32'h300);
    check("flush_imm_sel", {29'd0, out_imm_sel}, 32'd0);
    check("flush_rd", {27'd0, out_rd}, 32'd0);
    step(2);
    check("flush_dropped", {31'd0, out_valid}, 32'd0);

    // illegal encodings and other legal forms
    out_ready = 1'b1;
    stim_q.push_back(mk(32'h0000007F, 32'h400, 3'd0, 1'b1, 5'd0, 5'd0, 5'd0));
    stim_q.push_back(mk(32'h00000000, 32'h404, 3'd0, 1'b1, 5'd0, 5'd0, 5'd0));
    stim_q.push_back(mk(32'h002081B3, 32'h408, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2));
    stim_q.push_back(mk(32'h34029073, 32'h40C, 3'd0, 1'b0, 5'd0, 5'd5, 5'd0));
    stim_q.push_back(mk(32'h00000012, 32'h410, 3'd0, 1'b1, 5'd0, 5'd0, 5'd0));
    wait_drain("illegal");

    // asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    stim_q.push_back(mk(32'h00500093, 32'h500, 3'd0, 1'b0, 5'd1, 5'd0, 5'd5));
    stim_q.push_back(mk(32'h00112223, 32'h504, 3'd1, 1'b0, 5'd4, 5'd2, 5'd1));
    step(4);
    check("prerst_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    stim_q.delete();
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_inst", out_inst, 32'h0000_0013);
    check("arst_out_pc", out_pc, 32'h0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    step(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step(1);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    stim_q.push_back(mk(32'h002081B3, 32'h600, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2));
    wait_drain("post_rst");

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
